// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared constants for the Y86 pipeline condition-code logic:
//   - icode values that affect condition handling (IOPL, IJXX, ICMOVXX)
//   - ifun condition selectors (C_YES .. C_G)
//   - condition-code FSM states (ST_RUN, ST_FROZEN)
//   - bit positions of Z, S and O inside the packed {Z,S,O} vector
// ---------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes relevant to condition codes
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IOPL    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;

    // Condition selectors carried in ifun for jXX / cmovXX
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Condition-code FSM states
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_FROZEN = 1'b1;

    // Bit indices into the {Z,S,O} vector
    localparam int ZSO_Z = 2;
    localparam int ZSO_S = 1;
    localparam int ZSO_O = 0;

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational evaluation of a Y86 branch/move condition from the
// stored condition codes.
// Ports:
//   cc   in  [2:0]  stored condition codes {Z,S,O}
//   ifun in  [3:0]  condition selector
//   cnd  out        1 when the selected condition holds
// ---------------------------------------------------------------------------
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf;
    logic sf;
    logic of;
    logic lt;

    assign zf = cc[ZSO_Z];
    assign sf = cc[ZSO_S];
    assign of = cc[ZSO_O];

    // Signed "less than" after a subtract is sign differing from overflow
    assign lt = sf ^ of;

    // Selector decode; reserved selectors 7..15 never take
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_code_unit.sv
// ---------------------------------------------------------------------------
// cond_code_unit
// Condition-code register, execute-stage condition evaluation, memory-stage
// condition pipeline register and a saturating count of committed CC writes.
// A write-back exception freezes the CC register until reset.
//
// Build option: define COND_CMOV_EN to make cmovXX (icode 2) honour its
// condition; without it every cmov behaves as an unconditional rrmovl.
//
// Parameters:
//   CC_RST_VAL  reset value of {Z,S,O}
//   CNT_W       width of the CC-update counter
// Ports:
//   clk         in          clock, rising edge
//   rst_n       in          asynchronous active-low reset
//   e_zso       in  [2:0]   ALU flags {Z,S,O} of the execute-stage op
//   e_set_cc    in          execute-stage op requests a CC write
//   e_icode     in  [3:0]   execute-stage instruction code
//   e_ifun      in  [3:0]   execute-stage function code (condition)
//   m_exc       in          exception present in memory stage
//   w_exc       in          exception present in write-back stage
//   stall_m     in          hold the memory-stage register
//   bubble_m    in          clear the memory-stage register
//   cc_q        out [2:0]   registered condition codes {Z,S,O}
//   e_cnd       out         execute-stage condition result
//   m_cnd       out         e_cnd registered into the memory stage
//   frozen      out         FSM is in FROZEN
//   cc_upd_cnt  out [CNT_W] saturating count of committed CC writes
// ---------------------------------------------------------------------------
module cond_code_unit
    import y86_pkg::*;
#(
    parameter logic [2:0] CC_RST_VAL = 3'b100,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       e_zso,
    input  logic             e_set_cc,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic             m_exc,
    input  logic             w_exc,
    input  logic             stall_m,
    input  logic             bubble_m,
    output logic [2:0]       cc_q,
    output logic             e_cnd,
    output logic             m_cnd,
    output logic             frozen,
    output logic [CNT_W-1:0] cc_upd_cnt
);

    logic [0:0] state;
    logic       cond_raw;
    logic       cc_write;

    cond_eval u_cond_eval (
        .cc   (cc_q),
        .ifun (e_ifun),
        .cnd  (cond_raw)
    );

    // Only jXX (and cmovXX when enabled) are conditional; all other
    // instructions see a true condition.
    always_comb begin
        e_cnd = 1'b1;
        if (e_icode == IJXX) begin
            e_cnd = cond_raw;
        end
`ifdef COND_CMOV_EN
        else if (e_icode == ICMOVXX) begin
            e_cnd = cond_raw;
        end
`else
        else if (e_icode == ICMOVXX) begin
            e_cnd = 1'b1;
        end
`endif
    end

    // An exception anywhere downstream suppresses the write, so an excepting
    // instruction can never leave side effects in the flags.
    assign cc_write = e_set_cc & ~m_exc & ~w_exc & (state == ST_RUN);

    assign frozen = (state == ST_FROZEN);

    // FROZEN is absorbing; only reset returns to RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (w_exc) begin
            state <= ST_FROZEN;
        end
    end

    // Condition-code register and its saturating commit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q       <= CC_RST_VAL;
            cc_upd_cnt <= '0;
        end else if (cc_write) begin
            cc_q <= e_zso;
            if (cc_upd_cnt != {CNT_W{1'b1}}) begin
                cc_upd_cnt <= cc_upd_cnt + 1'b1;
            end
        end
    end

    // Memory-stage copy of the condition; bubble wins over stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnd <= 1'b0;
        end else if (bubble_m) begin
            m_cnd <= 1'b0;
        end else if (!stall_m) begin
            m_cnd <= e_cnd;
        end
    end

endmodule

// File: doc/cond_code_unit.md
COND_CODE_UNIT -- requirements
Module: cond_code_unit

Interface
REQ-001 SHALL have parameter CC_RST_VAL, default 3'b100, reset value of the {Z,S,O} condition-code register.
REQ-002 SHALL have parameter CNT_W, default 16, width of the CC-update counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port e_zso  input  3  ALU flags for the current execute-stage op: [2]=Z, [1]=S, [0]=O.
REQ-006 SHALL have port e_set_cc  input  1  the current execute-stage instruction requests a CC write (OPL class).
REQ-007 SHALL have port e_icode  input  4  execute-stage instruction code.
REQ-008 SHALL have port e_ifun  input  4  execute-stage function code, which selects the condition.
REQ-009 SHALL have ports m_exc and w_exc  input  1 each  an exception status is present in the memory or write-back stage.
REQ-010 SHALL have ports stall_m and bubble_m  input  1 each  memory-stage pipeline-register control.
REQ-011 SHALL have port cc_q  output  3  registered condition codes {Z,S,O}.
REQ-012 SHALL have port e_cnd  output  1  combinational condition result for the execute stage.
REQ-013 SHALL have port m_cnd  output  1  e_cnd registered into the memory stage.
REQ-014 SHALL have port frozen  output  1  high when the FSM is in FROZEN.
REQ-015 SHALL have port cc_upd_cnt  output  CNT_W  count of committed CC writes, saturating.

Function
REQ-016 SHALL implement a two-state FSM: RUN (the state after reset) and FROZEN.
REQ-017 SHALL move from RUN to FROZEN on a rising edge at which w_exc=1, and SHALL leave FROZEN only on reset.
REQ-018 SHALL commit a CC write, cc_q<=e_zso, at a rising edge only when e_set_cc=1, m_exc=0, w_exc=0 and the state is RUN.
REQ-019 SHALL hold cc_q unchanged at every other edge, including the edge on which the FSM enters FROZEN.
REQ-020 SHALL evaluate e_cnd from cc_q (never from e_zso) and e_ifun as follows: 0=1; 1=(S^O)|Z; 2=S^O; 3=Z; 4=~Z; 5=~(S^O); 6=~(S^O)&~Z; 7-15=0.
REQ-021 SHALL apply REQ-020 for e_icode 7 (jXX); for e_icode values other than 2 and 7, e_cnd SHALL be 1.
REQ-022 SHALL, at each edge, set m_cnd to 0 if bubble_m=1, hold m_cnd if stall_m=1, and otherwise load e_cnd; bubble_m SHALL take priority over stall_m.
REQ-023 SHALL increment cc_upd_cnt by 1 on each committed write and SHALL hold it at all-ones once it saturates.
REQ-024 SHALL, when e_set_cc and w_exc are both high at the same edge, perform no write, leave the counter unchanged and enter FROZEN.

Reset
REQ-025 SHALL, while rst_n=0 and independent of clk, force: cc_q=CC_RST_VAL, m_cnd=0, cc_upd_cnt=0, FSM state=RUN, frozen=0.
REQ-026 SHALL, when reset is asserted mid-operation, discard any pending write and leave FROZEN.

Configuration
REQ-027 SHALL, when macro COND_CMOV_EN is defined, evaluate e_icode 2 (cmovXX) per REQ-020.
REQ-028 SHALL, when COND_CMOV_EN is not defined, drive e_cnd=1 for e_icode 2, so that every cmov behaves as rrmovl.

Structure
REQ-029 SHALL take the icode constants (IOPL, IJXX, ICMOVXX), the ifun condition constants, the FSM state enumeration and the ZSO bit-index constants from a shared package y86_pkg.
REQ-030 SHALL place the condition evaluation in one combinational sub-module cond_eval (inputs cc, ifun; output cnd); the registers SHALL stay in the parent.

Verification
REQ-031 Bench SHALL check: reset, then e_icode=7, e_ifun=3 -> cc_q=3'b100, e_cnd=1; e_ifun=4 -> e_cnd=0.
REQ-032 Bench SHALL check: e_set_cc=1, e_zso=3'b011 for one edge -> cc_q=3'b011, cc_upd_cnt=1; ifun 2 -> e_cnd=0; ifun 5 -> e_cnd=1; ifun 1 -> e_cnd=0.
REQ-033 Bench SHALL check: e_set_cc=1 with m_exc=1, e_zso=3'b010 -> cc_q unchanged and counter unchanged.
REQ-034 Bench SHALL check: e_set_cc=1 with w_exc=1 at the same edge -> no write, frozen=1; later e_set_cc pulses leave cc_q fixed until rst_n pulses low, after which frozen=0 and cc_q=3'b100.
REQ-035 Bench SHALL check: e_cnd=1 with stall_m=1 -> m_cnd holds its previous value; stall_m=1 and bubble_m=1 together -> m_cnd=0 at the next edge.
REQ-036 Bench SHALL check: CNT_W=2 and 5 commits -> cc_upd_cnt=3 and stays at 3; e_icode=2, ifun=3, Z=0 -> e_cnd=0 when COND_CMOV_EN is defined and e_cnd=1 when it is not.
